// File: rtl/divider_scheduler.sv
// Round-robin front end sharing one iterative fixed-point divider
// between R requesters, with divide-by-zero bypass and a watchdog.
module divider_scheduler #(
  parameter int R       = 4,
  parameter int ID_W    = 2,
  parameter int N       = 32,
  parameter int Q       = 15,
  parameter int TIMEOUT = N + Q + 4
) (
  input  logic            iClk,
  input  logic            iRst_n,
  input  logic [R-1:0]    iReqValid,
  output logic [R-1:0]    oReqReady,
  input  logic [R*N-1:0]  iReqDividend,
  input  logic [R*N-1:0]  iReqDivisor,
  output logic            oRespValid,
  output logic [ID_W-1:0] oRespId,
  output logic [2*N:0]    oRespQuotient,
  output logic            oRespDivZero,
  input  logic            iRespReady,
  output logic            oDivStart,
  output logic [N-1:0]    oDivDividend,
  output logic [N-1:0]    oDivDivisor,
  input  logic [2*N:0]    iDivQuotient,
  input  logic            iDivComplete,
  output logic            oBusy,
  output logic            oTimeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_gnt;
  logic [N-1:0]    r_dvd;
  logic [N-1:0]    r_dvs;
  logic            r_start;
  logic            r_rvalid;
  logic [2*N:0]    r_rq;
  logic            r_rdz;
  logic            r_busy;
  logic            r_tout;
  logic            r_fault;
  logic [WD_W-1:0] r_wd;

  logic            w_found;
  logic [ID_W-1:0] w_idx;
  logic            w_grant;
  logic [N-1:0]    w_sel_dvd;
  logic [N-1:0]    w_sel_dvs;
  logic            w_zero;
  logic            w_fault;
  logic [ID_W-1:0] w_ptr_nxt;

  // Scan downward so the lowest offset from the pointer wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = R - 1; i >= 0; i--) begin
      if (iReqValid[(int'(r_ptr) + i) % R]) begin
        w_found = 1'b1;
        w_idx   = ID_W'((int'(r_ptr) + i) % R);
      end
    end
  end

  assign w_grant   = (r_state == S_IDLE) && iDivComplete && w_found;
  assign w_sel_dvd = iReqDividend[int'(w_idx)*N +: N];
  assign w_sel_dvs = iReqDivisor[int'(w_idx)*N +: N];
  assign w_zero    = (w_sel_dvs[N-2:0] == '0);
  assign w_ptr_nxt = (r_gnt == ID_W'(R - 1)) ? '0 : r_gnt + 1'b1;

  assign w_fault = (r_wd == WD_W'(TIMEOUT - 1)) &&
                   ((r_state == S_WAIT_BUSY) ||
                    (r_state == S_WAIT_DONE && !iDivComplete));

  assign oReqReady = w_grant ? ({{(R-1){1'b0}}, 1'b1} << w_idx) : '0;

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state  <= S_DRAIN;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_start  <= 1'b0;
      r_rvalid <= 1'b0;
      r_rq     <= '0;
      r_rdz    <= 1'b0;
      r_busy   <= 1'b0;
      r_tout   <= 1'b0;
      r_fault  <= 1'b0;
      r_wd     <= '0;
    end else begin
      unique case (r_state)
        S_DRAIN: begin
          r_busy <= !iDivComplete;
          if (iDivComplete) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (w_grant) begin
            r_gnt  <= w_idx;
            r_dvd  <= w_sel_dvd;
            r_dvs  <= w_sel_dvs;
            r_busy <= 1'b1;
            if (w_zero) begin
              r_rq     <= {w_sel_dvd[N-1] ^ w_sel_dvs[N-1],
                           {(2*N){1'b1}}};
              r_rdz    <= 1'b1;
              r_rvalid <= 1'b1;
              r_state  <= S_RESP;
            end else begin
              r_start <= 1'b1;
              r_state <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          r_start <= 1'b0;
          r_wd    <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          r_wd <= r_wd + 1'b1;
          if (!iDivComplete) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (iDivComplete) begin
            r_rq     <= iDivQuotient;
            r_rdz    <= 1'b0;
            r_rvalid <= 1'b1;
            r_state  <= S_RESP;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_RESP: begin
          if (iRespReady) begin
            r_rvalid <= 1'b0;
            r_ptr    <= w_ptr_nxt;
            r_fault  <= 1'b0;
            r_busy   <= r_fault;
            r_state  <= r_fault ? S_DRAIN : S_IDLE;
          end
        end
        default: r_state <= S_DRAIN;
      endcase
      // Hung divider: answer with zero, then drain before reuse.
      if (w_fault) begin
        r_tout   <= 1'b1;
        r_fault  <= 1'b1;
        r_rq     <= '0;
        r_rdz    <= 1'b0;
        r_rvalid <= 1'b1;
        r_state  <= S_RESP;
      end
    end
  end

  assign oRespValid    = r_rvalid;
  assign oRespId       = r_gnt;
  assign oRespQuotient = r_rq;
  assign oRespDivZero  = r_rdz;
  assign oDivStart     = r_start;
  assign oDivDividend  = r_dvd;
  assign oDivDivisor   = r_dvs;
  assign oBusy         = r_busy;
  assign oTimeout      = r_tout;

endmodule

// File: tb/tb_divider_scheduler.sv
// Self-checking bench for divider_scheduler with a behavioural
// divider model and a round-robin reference model.
module tb_divider_scheduler;

  localparam int R       = 4;
  localparam int ID_W    = 2;
  localparam int N       = 32;
  localparam int Q       = 15;
  localparam int TIMEOUT = N + Q + 4;
  localparam int D       = N + Q;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [R-1:0]    req_valid = '0;
  logic [R-1:0]    req_ready;
  logic [R*N-1:0]  req_dvd = '0;
  logic [R*N-1:0]  req_dvs = '0;
  logic            resp_valid;
  logic [ID_W-1:0] resp_id;
  logic [2*N:0]    resp_q;
  logic            resp_dz;
  logic            resp_ready = 1'b0;
  logic            div_start;
  logic [N-1:0]    div_dvd;
  logic [N-1:0]    div_dvs;
  logic [2*N:0]    dv_q = '0;
  logic            div_complete;
  logic            busy;
  logic            tout;

  always #5 clk = ~clk;

  divider_scheduler #(
    .R(R), .ID_W(ID_W), .N(N), .Q(Q), .TIMEOUT(TIMEOUT)
  ) dut (
    .iClk(clk),
    .iRst_n(rst_n),
    .iReqValid(req_valid),
    .oReqReady(req_ready),
    .iReqDividend(req_dvd),
    .iReqDivisor(req_dvs),
    .oRespValid(resp_valid),
    .oRespId(resp_id),
    .oRespQuotient(resp_q),
    .oRespDivZero(resp_dz),
    .iRespReady(resp_ready),
    .oDivStart(div_start),
    .oDivDividend(div_dvd),
    .oDivDivisor(div_dvs),
    .iDivQuotient(dv_q),
    .iDivComplete(div_complete),
    .oBusy(busy),
    .oTimeout(tout)
  );

  int checks = 0;
  int errors = 0;
  int ref_ptr = 0;
  int cyc = 0;
  int starts = 0;
  logic [N-1:0] op_a [R];
  logic [N-1:0] op_b [R];

  function automatic logic [2*N:0] fx_div(logic [N-1:0] a, logic [N-1:0] b);
    logic [2*N-1:0] num, den;
    num = {{(N+1){1'b0}}, a[N-2:0]} << Q;
    den = {{(N+1){1'b0}}, b[N-2:0]};
    return {a[N-1] ^ b[N-1], num / den};
  endfunction

  // Divider model: busy for D cycles after start, no reset, can hang.
  logic dv_busy = 1'b0;
  logic dv_hang = 1'b0;
  int   dv_cnt = 0;
  logic [N-1:0] dv_a = '0;
  logic [N-1:0] dv_b = '0;
  assign div_complete = !dv_busy;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_start) begin
      starts  <= starts + 1;
      dv_busy <= 1'b1;
      dv_cnt  <= D;
      dv_a    <= div_dvd;
      dv_b    <= div_dvs;
    end else if (dv_busy && !dv_hang) begin
      if (dv_cnt == 1) begin
        dv_busy <= 1'b0;
        dv_q    <= fx_div(dv_a, dv_b);
      end
      dv_cnt <= dv_cnt - 1;
    end
  end

  function automatic int pick(logic [R-1:0] m, int p);
    for (int i = 0; i < R; i++)
      if (m[(p + i) % R]) return (p + i) % R;
    return -1;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input logic [N-1:0] a, input logic [N-1:0] b);
    op_a[k] = a;
    op_b[k] = b;
    req_dvd[k*N +: N] = a;
    req_dvs[k*N +: N] = b;
  endtask

  task automatic check_all_zero(input string name);
    logic [R+2*N+ID_W+2*N+7-1:0] v;
    v = {req_ready, resp_valid, resp_id, resp_q, resp_dz,
         div_start, div_dvd, div_dvs, busy, tout};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s outputs=%h required 0", name, v);
    end
  endtask

  task automatic run_txn(input logic [R-1:0] mask, input int stall,
                         input logic [R-1:0] hold, output int gid,
                         output logic [2*N:0] obs_q);
    int eg, t0, s0, n, lat, elat;
    logic [R-1:0] erdy;
    logic [2*N:0] eq;
    logic edz;
    logic [N-1:0] a, b;
    logic [ID_W+2*N+1:0] held;
    eg = pick(mask, ref_ptr);
    erdy = R'(1) << eg;
    req_valid = mask;
    #1;
    n = 0;
    while (req_ready == '0 && n < 300) begin
      step;
      #1;
      n++;
    end
    checks++;
    if (req_ready !== erdy) begin
      errors++;
      $display("FAIL grant got %b required %b", req_ready, erdy);
    end
    gid = eg;
    a = op_a[eg];
    b = op_b[eg];
    if (b[N-2:0] == '0) begin
      edz = 1'b1;
      eq = {a[N-1] ^ b[N-1], {(2*N){1'b1}}};
      elat = 1;
    end else if (dv_hang) begin
      edz = 1'b0;
      eq = '0;
      elat = TIMEOUT + 2;
    end else begin
      edz = 1'b0;
      eq = fx_div(a, b);
      elat = D + 3;
    end
    s0 = starts;
    step;
    req_valid = '0;
    t0 = cyc - 1;
    n = 0;
    while (!resp_valid && n < TIMEOUT + 100) begin
      step;
      n++;
    end
    lat = cyc - t0;
    checks++;
    if (lat != elat) begin
      errors++;
      $display("FAIL latency got %0d required %0d", lat, elat);
    end
    checks++;
    if ({resp_id, resp_q, resp_dz} !== {ID_W'(eg), eq, edz}) begin
      errors++;
      $display("FAIL resp id=%0d q=%h dz=%b required id=%0d q=%h dz=%b",
               resp_id, resp_q, resp_dz, eg, eq, edz);
    end
    checks++;
    if (starts - s0 != (edz ? 0 : 1)) begin
      errors++;
      $display("FAIL start_pulses got %0d required %0d", starts - s0, edz ? 0 : 1);
    end
    if (!edz) begin
      checks++;
      if ({div_dvd, div_dvs} !== {a, b}) begin
        errors++;
        $display("FAIL div_operands got %h/%h required %h/%h", div_dvd, div_dvs, a, b);
      end
    end
    obs_q = resp_q;
    held = {resp_id, resp_q, resp_dz};
    s0 = starts;
    req_valid = hold;
    for (int i = 0; i < stall; i++) begin
      step;
      checks++;
      if ({resp_valid, resp_id, resp_q, resp_dz} !== {1'b1, held} ||
          req_ready !== '0 || starts != s0) begin
        errors++;
        $display("FAIL stall_hold v=%b id=%0d q=%h rdy=%b starts=%0d",
                 resp_valid, resp_id, resp_q, req_ready, starts - s0);
      end
    end
    resp_ready = 1'b1;
    step;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL resp_drop got %b required 0", resp_valid);
    end
    ref_ptr = (eg + 1) % R;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = '1;
    step;
    step;
    check_all_zero("reset");
    rst_n = 1'b1;
    req_valid = '0;
    ref_ptr = 0;
    step;
    step;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got %b required 0", busy);
    end
  endtask

  task automatic test_round_robin;
    int g;
    logic [2*N:0] q;
    for (int k = 0; k < R; k++) set_op(k, N'(100 + k), N'(k + 1));
    for (int k = 0; k < R; k++) run_txn('1, 0, '0, g, q);
    run_txn(4'b1010, 0, '0, g, q);
    run_txn(4'b1010, 0, '0, g, q);
  endtask

  task automatic test_basic;
    int g;
    logic [2*N:0] q;
    set_op(0, 32'd6, 32'd3);
    run_txn(4'b0001, 0, '0, g, q);
    checks++;
    if (q !== {1'b0, 64'd65536}) begin
      errors++;
      $display("FAIL basic_6_3 got %h required %h", q, {1'b0, 64'd65536});
    end
    set_op(0, 32'h8000_0006, 32'd3);
    run_txn(4'b0001, 0, '0, g, q);
    checks++;
    if (q !== {1'b1, 64'd65536}) begin
      errors++;
      $display("FAIL signed_6_3 got %h required %h", q, {1'b1, 64'd65536});
    end
  endtask

  task automatic test_divzero;
    int g;
    logic [2*N:0] q;
    set_op(2, 32'd5, 32'h8000_0000);
    run_txn(4'b0100, 0, '0, g, q);
    checks++;
    if (q !== {1'b1, {(2*N){1'b1}}}) begin
      errors++;
      $display("FAIL divzero_q got %h required all ones with sign", q);
    end
  endtask

  task automatic test_stall;
    int g;
    logic [R-1:0] erdy;
    logic [2*N:0] q;
    set_op(3, 32'd1000, 32'd9);
    run_txn(4'b1000, 10, 4'b1111, g, q);
    erdy = R'(1) << pick(4'b1111, ref_ptr);
    checks++;
    if (req_ready !== erdy) begin
      errors++;
      $display("FAIL regrant got %b required %b", req_ready, erdy);
    end
    req_valid = '0;
    step;
  endtask

  task automatic test_reset_mid;
    int s0, n, g;
    logic [2*N:0] q;
    set_op(1, 32'd100, 32'd7);
    req_valid = 4'b0010;
    n = 0;
    while (starts == 0 && n < 0) n++;
    s0 = starts;
    n = 0;
    while (starts == s0 && n < 50) begin
      step;
      n++;
    end
    req_valid = '0;
    for (int i = 0; i < 5; i++) step;
    rst_n = 1'b0;
    step;
    check_all_zero("reset_mid");
    rst_n = 1'b1;
    ref_ptr = 0;
    req_valid = '1;
    s0 = starts;
    for (int i = 0; i < 10; i++) begin
      step;
      checks++;
      if (req_ready !== '0 || busy !== 1'b1 || div_start !== 1'b0 ||
          resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL drain_hold rdy=%b busy=%b start=%b rv=%b",
                 req_ready, busy, div_start, resp_valid);
      end
    end
    req_valid = '0;
    n = 0;
    while (!div_complete && n < 200) begin
      step;
      n++;
    end
    step;
    checks++;
    if (starts != s0) begin
      errors++;
      $display("FAIL drain_start got %0d pulses required 0", starts - s0);
    end
    set_op(2, 32'd77, 32'd4);
    run_txn(4'b0100, 0, '0, g, q);
  endtask

  task automatic test_timeout;
    int g, n;
    logic [2*N:0] q;
    checks++;
    if (tout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pre got %b required 0", tout);
    end
    dv_hang = 1'b1;
    set_op(0, 32'd12, 32'd5);
    run_txn(4'b0001, 0, '0, g, q);
    checks++;
    if (tout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flag got %b required 1", tout);
    end
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      step;
      checks++;
      if (req_ready !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL post_fault_drain rdy=%b busy=%b required 0/1", req_ready, busy);
      end
    end
    req_valid = '0;
    dv_hang = 1'b0;
    n = 0;
    while (!div_complete && n < 200) begin
      step;
      n++;
    end
    step;
    step;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_exit got busy=%b required 0", busy);
    end
    set_op(0, 32'd9, 32'd2);
    run_txn(4'b0001, 0, '0, g, q);
    checks++;
    if (tout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky got %b required 1", tout);
    end
  endtask

  task automatic test_random;
    int g;
    logic [2*N:0] q;
    logic [N-1:0] b;
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < R; k++) begin
        b = $urandom;
        if ($urandom_range(0, 3) == 0) b[N-2:0] = '0;
        set_op(k, $urandom, b);
      end
      run_txn(R'($urandom_range(1, 15)), $urandom_range(0, 3),
              R'($urandom_range(0, 15)), g, q);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_basic;
    test_divzero;
    test_stall;
    test_reset_mid;
    test_timeout;
    test_random;
    test_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_scheduler.md
Name: divider_scheduler

Overview:
- Shares one sequential fixed-point divider (sign-magnitude, Q fractional bits, N+Q-cycle iterative) between R requesters, e.g. reservoir neuron normalisation units.
- Arbitrates requests round-robin, launches the divider with a one-cycle start pulse, waits for completion and returns the quotient tagged with the requester id.
- Short-circuits divide-by-zero without occupying the divider, and guards against a hung divider with a watchdog.

Parameters:
R, 4, number of requesters
ID_W, 2, requester id width (ceil log2 R)
N, 32, operand width (bit N-1 sign, N-2:0 magnitude)
Q, 15, fractional bits of divider result
TIMEOUT, N+Q+4, max cycles waiting on divider before fault

Ports:
iClk  in  1  clock
iRst_n  in  1  synchronous active-low reset
iReqValid  in  R  per-requester request valid
oReqReady  out  R  one-hot grant/accept
iReqDividend  in  R*N  requester k at [k*N +: N]
iReqDivisor  in  R*N  requester k at [k*N +: N]
oRespValid  out  1  response valid
oRespId  out  ID_W  requester served
oRespQuotient  out  2N+1  bit 2N sign, 2N-1:0 magnitude
oRespDivZero  out  1  response is divide-by-zero result
iRespReady  in  1  response accepted
oDivStart  out  1  divider start pulse
oDivDividend  out  N  divider dividend
oDivDivisor  out  N  divider divisor
iDivQuotient  in  2N+1  divider quotient
iDivComplete  in  1  divider idle/done flag
oBusy  out  1  state != IDLE
oTimeout  out  1  sticky watchdog fault

Behaviour:
- Reset (iRst_n=0 at posedge): all outputs 0, rr pointer 0, watchdog 0, oTimeout cleared, state DRAIN. The divider has no reset, so the scheduler must not start it until it is idle.
- DRAIN: wait for iDivComplete=1, then go to IDLE. oBusy=1.
- IDLE: if any iReqValid and iDivComplete=1, grant the first valid index searching from ptr upward with wrap. oReqReady[g]=1 combinationally that cycle only; register operands and g at the edge. No grant when no request is valid.
- Zero check on captured divisor[N-2:0]==0: go to RESP with quotient = {dividend[N-1]^divisor[N-1], all-ones magnitude} and DivZero=1; oDivStart never asserted. Otherwise go to LAUNCH.
- LAUNCH: oDivStart=1 for exactly one cycle, operands stable on oDivDividend/oDivDivisor from LAUNCH until the response. Next state WAIT_BUSY, watchdog cleared.
- WAIT_BUSY: wait for iDivComplete=0, then go to WAIT_DONE.
- WAIT_DONE: on iDivComplete=1, capture iDivQuotient into the response register and go to RESP. oRespValid rises on the cycle after completion is seen.
- Watchdog: counts every cycle in WAIT_BUSY/WAIT_DONE. When it reaches TIMEOUT:
  - set oTimeout (sticky until reset);
  - respond with quotient 0, DivZero 0;
  - after response acceptance go to DRAIN, not IDLE.
- RESP: oRespValid=1. oRespId, oRespQuotient and oRespDivZero are held stable until iRespReady=1. On acceptance:
  - ptr = (g+1) mod R;
  - oRespValid drops next cycle;
  - go to IDLE.
- No new grant while a response is pending: one request in flight.
- A requester dropping iReqValid before grant is simply skipped. Valid and ready in the same cycle is the transfer.
- Reset mid-operation (any state) returns to DRAIN. The in-flight request is lost, no response is issued.
- Latency, grant to oRespValid: normal path = divider latency + 3 cycles; zero path = 1 cycle.

Test Plan:
- Req0 dividend 6, divisor 3 (Q=15) -> one oDivStart pulse, oRespId=0, magnitude 65536, sign 0, DivZero 0.
- Req0 dividend 0x80000006, divisor 3 -> sign bit 1, magnitude 65536.
- All four iReqValid held high -> responses in id order 0,1,2,3. Then requesters 1 and 3 valid (ptr=0) -> order 1,3.
- Req2 dividend 5, divisor 0x80000000 -> no oDivStart, oRespValid 1 cycle after grant, DivZero 1, sign 1, magnitude all ones.
- iRespReady low for 10 cycles during RESP -> response fields stable, all oReqReady 0, no oDivStart. Accept -> next grant in following IDLE cycle.
- Reset pulse in WAIT_DONE -> all outputs 0, no oDivStart until iDivComplete=1, then next request completes correctly.
- Divider model that never completes -> oTimeout=1 after TIMEOUT cycles, response quotient 0, state DRAIN after acceptance.
